divisor_frequencia_prog: RTL and testbench

Parametrised, runtime-programmable frequency divider for the panel's timing chain. It generalises the fixed twisted-ring divider into a modulo-D counter, where D can be loaded at run time. It provides a near-50% duty output Q, a one-cycle TICK strobe per output period, an enable, and a synchronous restart. Downstream blocks (display multiplexing, blink, seconds counters) use TICK as a clock enable rather than deriving new clocks.

---
 rtl/divisor_frequencia_prog_pkg.sv | 12 +
 rtl/divisor_frequencia_prog_contador_modulo_n.sv | 30 +++
 rtl/divisor_frequencia_prog.sv | 104 ++++++++++
 tb/tb_divisor_frequencia_prog.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/divisor_frequencia_prog_pkg.sv
// Shared constants and helpers for the programmable frequency divider.
package divisor_defs;

  localparam int unsigned DEFAULT_WIDTH = 16;
  localparam int unsigned MIN_DIV       = 2;

  // First count value at which Q is high: D - floor(D/2) = ceil(D/2).
  function automatic logic [31:0] q_threshold(input logic [31:0] d);
    return d - (d >> 1);
  endfunction

endpackage

// File: rtl/divisor_frequencia_prog_contador_modulo_n.sv
// Modulo-D counter: counts 0..D-1 on enabled edges, CLR restarts at 0.
module contador_modulo_n
  import divisor_defs::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             CLR,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] cnt,
  output logic             wrap
);

  // wrap flags the enabled edge on which cnt returns from D-1 to 0.
  assign wrap = EN && (cnt == D - WIDTH'(1));

  // Counter register: reset, then restart, then enabled count.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt <= '0;
    end else if (CLR) begin
      cnt <= '0;
    end else if (EN) begin
      cnt <= wrap ? '0 : cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/divisor_frequencia_prog.sv
// Runtime-programmable frequency divider with Q output, TICK strobe,
// deferred divisor loading and sticky illegal-divisor flag.
module divisor_frequencia_prog
  import divisor_defs::*;
#(
  parameter int unsigned WIDTH       = DEFAULT_WIDTH,
  parameter int unsigned DEFAULT_DIV = 10
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             SYNC,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] DIV,
  output logic             Q,
  output logic             TICK,
  output logic [WIDTH-1:0] COUNT,
  output logic [WIDTH-1:0] DIV_CUR,
  output logic             ERR
);

  localparam logic [WIDTH-1:0] DEFAULT_D = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] MIN_D     = WIDTH'(MIN_DIV);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] div_legal;
  logic             pend_valid;
  logic             div_bad;
  logic             wrap;
  logic             q_next;

  assign div_bad   = (DIV < MIN_D);
  assign div_legal = div_bad ? MIN_D : DIV;

  contador_modulo_n #(
    .WIDTH(WIDTH)
  ) u_contador (
    .CLK  (CLK),
    .RST  (RST),
    .EN   (EN),
    .CLR  (SYNC),
    .D    (d),
    .cnt  (cnt),
    .wrap (wrap)
  );

  // Q is computed from the counter's next value so the register tracks cnt
  // on the same edge; after a wrap cnt is 0, which is always below threshold.
  always_comb begin
    q_next = 1'b0;
    if (!wrap) begin
      q_next = ((32'(cnt) + 32'd1) >= q_threshold(32'(d)));
    end
  end

  // Q and TICK output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      Q    <= 1'b0;
      TICK <= 1'b0;
    end else if (SYNC) begin
      Q    <= 1'b0;
      TICK <= 1'b0;
    end else begin
      if (EN) begin
        Q <= q_next;
      end
      TICK <= wrap;
    end
  end

  // Divisor, pending load and error flag: loads are applied at a wrap or
  // SYNC (a simultaneous LOAD wins over an older pending value), otherwise
  // parked in pending until the next wrap.
  always_ff @(posedge CLK) begin
    if (RST) begin
      d          <= DEFAULT_D;
      pending    <= '0;
      pend_valid <= 1'b0;
      ERR        <= 1'b0;
    end else begin
      if (LOAD) begin
        ERR <= div_bad;
      end
      if (SYNC || wrap) begin
        if (LOAD) begin
          d <= div_legal;
        end else if (pend_valid) begin
          d <= pending;
        end
        pend_valid <= 1'b0;
      end else if (LOAD) begin
        pending    <= div_legal;
        pend_valid <= 1'b1;
      end
    end
  end

  assign COUNT   = cnt;
  assign DIV_CUR = d;

endmodule

// File: tb/tb_divisor_frequencia_prog.sv
// Directed self-checking bench for divisor_frequencia_prog.
module tb_divisor_frequencia_prog;

  logic        CLK;
  logic        RST;
  logic        EN;
  logic        SYNC;
  logic        LOAD;
  logic [15:0] DIV;
  logic        Q;
  logic        TICK;
  logic [15:0] COUNT;
  logic [15:0] DIV_CUR;
  logic        ERR;

  int checks;
  int failures;

  divisor_frequencia_prog #(
    .WIDTH      (16),
    .DEFAULT_DIV(10)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .EN     (EN),
    .SYNC   (SYNC),
    .LOAD   (LOAD),
    .DIV    (DIV),
    .Q      (Q),
    .TICK   (TICK),
    .COUNT  (COUNT),
    .DIV_CUR(DIV_CUR),
    .ERR    (ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance one rising edge and sample 1 time unit later.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Restart with an immediately applied divisor (SYNC + LOAD together).
  task automatic sync_load(input logic [15:0] v);
    SYNC = 1'b1; LOAD = 1'b1; DIV = v;
    step();
    SYNC = 1'b0; LOAD = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; EN = 1'b0; SYNC = 1'b0; LOAD = 1'b0; DIV = '0;
    step(); step();
    checks++;
    if (COUNT !== 16'd0) begin failures++; $display("FAIL reset_count: got %0d expected 0", COUNT); end
    checks++;
    if (Q !== 1'b0) begin failures++; $display("FAIL reset_q: got %b expected 0", Q); end
    checks++;
    if (TICK !== 1'b0) begin failures++; $display("FAIL reset_tick: got %b expected 0", TICK); end
    checks++;
    if (DIV_CUR !== 16'd10) begin failures++; $display("FAIL reset_div: got %0d expected 10", DIV_CUR); end
    checks++;
    if (ERR !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", ERR); end
    RST = 1'b0;
  endtask

  task automatic test_div10();
    logic [15:0] ec;
    logic eq, et;
    EN = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      ec = 16'(i % 10); eq = (ec >= 16'd5); et = (ec == 16'd0);
      checks++;
      if ({COUNT, Q, TICK} !== {ec, eq, et}) begin
        failures++;
        $display("FAIL div10 edge %0d: got cnt=%0d q=%b tick=%b expected cnt=%0d q=%b tick=%b",
                 i, COUNT, Q, TICK, ec, eq, et);
      end
    end
  endtask

  task automatic test_div5_div2();
    logic [15:0] ec;
    logic eq, et;
    sync_load(16'd5);
    checks++;
    if ({COUNT, Q, TICK, DIV_CUR} !== {16'd0, 1'b0, 1'b0, 16'd5}) begin
      failures++;
      $display("FAIL load5: got cnt=%0d q=%b tick=%b div=%0d expected 0 0 0 5", COUNT, Q, TICK, DIV_CUR);
    end
    for (int i = 1; i <= 10; i++) begin
      step();
      ec = 16'(i % 5); eq = (ec >= 16'd3); et = (ec == 16'd0);
      checks++;
      if ({COUNT, Q, TICK} !== {ec, eq, et}) begin
        failures++;
        $display("FAIL div5 edge %0d: got cnt=%0d q=%b tick=%b expected cnt=%0d q=%b tick=%b",
                 i, COUNT, Q, TICK, ec, eq, et);
      end
    end
    sync_load(16'd2);
    for (int i = 1; i <= 6; i++) begin
      step();
      ec = 16'(i % 2); eq = (ec >= 16'd1); et = (ec == 16'd0);
      checks++;
      if ({COUNT, Q, TICK, DIV_CUR} !== {ec, eq, et, 16'd2}) begin
        failures++;
        $display("FAIL div2 edge %0d: got cnt=%0d q=%b tick=%b div=%0d expected cnt=%0d q=%b tick=%b div=2",
                 i, COUNT, Q, TICK, DIV_CUR, ec, eq, et);
      end
    end
  endtask

  task automatic test_load_midperiod();
    logic [15:0] ec;
    logic eq, et;
    sync_load(16'd10);
    step(); step(); step();
    LOAD = 1'b1; DIV = 16'd4;
    step();
    LOAD = 1'b0;
    for (int i = 4; i <= 9; i++) begin
      if (i > 4) step();
      checks++;
      if ({COUNT, DIV_CUR} !== {16'(i), 16'd10}) begin
        failures++;
        $display("FAIL midload_hold cnt %0d: got cnt=%0d div=%0d expected div=10", i, COUNT, DIV_CUR);
      end
    end
    step();
    checks++;
    if ({COUNT, TICK, DIV_CUR} !== {16'd0, 1'b1, 16'd4}) begin
      failures++;
      $display("FAIL midload_apply: got cnt=%0d tick=%b div=%0d expected 0 1 4", COUNT, TICK, DIV_CUR);
    end
    for (int i = 1; i <= 8; i++) begin
      step();
      ec = 16'(i % 4); eq = (ec >= 16'd2); et = (ec == 16'd0);
      checks++;
      if ({COUNT, Q, TICK} !== {ec, eq, et}) begin
        failures++;
        $display("FAIL div4 edge %0d: got cnt=%0d q=%b tick=%b expected cnt=%0d q=%b tick=%b",
                 i, COUNT, Q, TICK, ec, eq, et);
      end
    end
  endtask

  task automatic test_illegal_div();
    // Starts at cnt=0 with D=4.
    LOAD = 1'b1; DIV = 16'd1;
    step();
    LOAD = 1'b0;
    checks++;
    if ({COUNT, ERR, DIV_CUR} !== {16'd1, 1'b1, 16'd4}) begin
      failures++;
      $display("FAIL illegal_capture: got cnt=%0d err=%b div=%0d expected 1 1 4", COUNT, ERR, DIV_CUR);
    end
    step(); step(); step();
    checks++;
    if ({COUNT, TICK, ERR, DIV_CUR} !== {16'd0, 1'b1, 1'b1, 16'd2}) begin
      failures++;
      $display("FAIL illegal_apply: got cnt=%0d tick=%b err=%b div=%0d expected 0 1 1 2",
               COUNT, TICK, ERR, DIV_CUR);
    end
    step(); step();
    checks++;
    if ({COUNT, TICK, ERR} !== {16'd0, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL illegal_sticky: got cnt=%0d tick=%b err=%b expected 0 1 1", COUNT, TICK, ERR);
    end
    LOAD = 1'b1; DIV = 16'd6;
    step();
    LOAD = 1'b0;
    checks++;
    if ({COUNT, ERR, DIV_CUR} !== {16'd1, 1'b0, 16'd2}) begin
      failures++;
      $display("FAIL legal_clears_err: got cnt=%0d err=%b div=%0d expected 1 0 2", COUNT, ERR, DIV_CUR);
    end
    step();
    checks++;
    if ({COUNT, TICK, DIV_CUR} !== {16'd0, 1'b1, 16'd6}) begin
      failures++;
      $display("FAIL legal_apply: got cnt=%0d tick=%b div=%0d expected 0 1 6", COUNT, TICK, DIV_CUR);
    end
  endtask

  task automatic test_enable_stall();
    sync_load(16'd10);
    for (int i = 0; i < 7; i++) step();
    checks++;
    if ({COUNT, Q} !== {16'd7, 1'b1}) begin
      failures++;
      $display("FAIL stall_pre: got cnt=%0d q=%b expected 7 1", COUNT, Q);
    end
    EN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({COUNT, Q, TICK} !== {16'd7, 1'b1, 1'b0}) begin
        failures++;
        $display("FAIL stall_hold %0d: got cnt=%0d q=%b tick=%b expected 7 1 0", i, COUNT, Q, TICK);
      end
    end
    EN = 1'b1;
    for (int i = 8; i <= 10; i++) begin
      step();
      checks++;
      if ({COUNT, TICK} !== {16'(i % 10), (i == 10)}) begin
        failures++;
        $display("FAIL stall_resume %0d: got cnt=%0d tick=%b expected cnt=%0d tick=%b",
                 i, COUNT, TICK, i % 10, (i == 10));
      end
    end
    EN = 1'b0;
    step();
    checks++;
    if ({COUNT, Q, TICK} !== {16'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL stall_tick_drop: got cnt=%0d q=%b tick=%b expected 0 0 0", COUNT, Q, TICK);
    end
    EN = 1'b1;
  endtask

  task automatic test_sync_load();
    logic [15:0] ec;
    logic eq, et;
    sync_load(16'd10);
    for (int i = 0; i < 6; i++) step();
    SYNC = 1'b1; LOAD = 1'b1; DIV = 16'd8;
    step();
    SYNC = 1'b0; LOAD = 1'b0;
    checks++;
    if ({COUNT, Q, TICK, DIV_CUR} !== {16'd0, 1'b0, 1'b0, 16'd8}) begin
      failures++;
      $display("FAIL sync_load8: got cnt=%0d q=%b tick=%b div=%0d expected 0 0 0 8", COUNT, Q, TICK, DIV_CUR);
    end
    for (int i = 1; i <= 8; i++) begin
      step();
      ec = 16'(i % 8); eq = (ec >= 16'd4); et = (i == 8);
      checks++;
      if ({COUNT, Q, TICK} !== {ec, eq, et}) begin
        failures++;
        $display("FAIL sync_div8 edge %0d: got cnt=%0d q=%b tick=%b expected cnt=%0d q=%b tick=%b",
                 i, COUNT, Q, TICK, ec, eq, et);
      end
    end
    step(); step();
    LOAD = 1'b1; DIV = 16'd3;
    step();
    LOAD = 1'b0;
    SYNC = 1'b1;
    step();
    SYNC = 1'b0;
    checks++;
    if ({COUNT, DIV_CUR} !== {16'd0, 16'd3}) begin
      failures++;
      $display("FAIL sync_pending: got cnt=%0d div=%0d expected 0 3", COUNT, DIV_CUR);
    end
    step(); step(); step();
    checks++;
    if ({COUNT, TICK} !== {16'd0, 1'b1}) begin
      failures++;
      $display("FAIL sync_div3_tick: got cnt=%0d tick=%b expected 0 1", COUNT, TICK);
    end
    step(); step();
    EN = 1'b0; SYNC = 1'b1;
    step();
    SYNC = 1'b0;
    checks++;
    if ({COUNT, Q} !== {16'd0, 1'b0}) begin
      failures++;
      $display("FAIL sync_no_en: got cnt=%0d q=%b expected 0 0", COUNT, Q);
    end
    EN = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic [15:0] ec;
    sync_load(16'd10);
    step(); step();
    LOAD = 1'b1; DIV = 16'd0;
    step();
    LOAD = 1'b0;
    checks++;
    if ({ERR, DIV_CUR} !== {1'b1, 16'd10}) begin
      failures++;
      $display("FAIL zero_div_err: got err=%b div=%0d expected 1 10", ERR, DIV_CUR);
    end
    step(); step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    checks++;
    if ({COUNT, Q, TICK, DIV_CUR, ERR} !== {16'd0, 1'b0, 1'b0, 16'd10, 1'b0}) begin
      failures++;
      $display("FAIL mid_reset: got cnt=%0d q=%b tick=%b div=%0d err=%b expected 0 0 0 10 0",
               COUNT, Q, TICK, DIV_CUR, ERR);
    end
    for (int i = 1; i <= 12; i++) begin
      step();
      ec = 16'(i % 10);
      checks++;
      if ({COUNT, DIV_CUR} !== {ec, 16'd10}) begin
        failures++;
        $display("FAIL post_reset edge %0d: got cnt=%0d div=%0d expected cnt=%0d div=10",
                 i, COUNT, DIV_CUR, ec);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    RST = 1'b1; EN = 1'b0; SYNC = 1'b0; LOAD = 1'b0; DIV = '0;
    test_reset();
    test_div10();
    test_div5_div2();
    test_load_midperiod();
    test_illegal_div();
    test_enable_stall();
    test_sync_load();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
